sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver for the timer front panel.
//  Scans one digit per refresh slot, with per-digit decimal points, a per-digit blank mask,
//  optional leading-zero blanking and inter-digit dead time (anti-ghosting).
//  Input digits are captured once per frame, so a displayed frame never mixes old and new values.
//  Sits between the timer BCD/hex value registers and the board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned, legal range 1..8; digit 0 = least significant
//  REFRESH_DIV  50000   clocks per digit slot, >= 2
//  DEAD_CYCLES  2       clocks at the start of each slot with all anodes off, 1..REFRESH_DIV-1
//  HEX_MODE     0       0: codes 10-15 display '9' (clamp); 1: codes 10-15 display A,b,C,d,E,F
// PORTS
//  clk         in   1             system clock
//  rst         in   1             synchronous, active-high reset
//  digits      in   4*NUM_DIGITS  digit codes; digit i = digits[4i+3:4i]
//  dp          in   NUM_DIGITS    decimal point request per digit, 1 = on
//  blank       in   NUM_DIGITS    force digit dark, 1 = blank
//  lzb_en      in   1             enable leading-zero blanking
//  an          out  NUM_DIGITS    digit anode enables, ACTIVE LOW
//  seg         out  7             segments, ACTIVE LOW; seg[0]=a ... seg[6]=g
//  dp_n        out  1             decimal point segment, ACTIVE LOW
//  frame_tick  out  1             one-cycle pulse per frame capture
// BEHAVIOUR
//  - Reset: cnt=0, idx=0, shadow regs=0; an=all 1, seg=7'h7F, dp_n=1, frame_tick=0.
//  - cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx advances; idx wraps NUM_DIGITS-1 -> 0.
//  - Capture: when cnt==0 && idx==0 (includes first cycle after reset), shadow <= {digits,dp,blank,lzb_en}.
//    Mid-frame input changes are ignored until the next capture.
//  - Outputs are registered; they reflect (cnt,idx,shadow) of the previous cycle, i.e. latency = 1 clk.
//  - cnt < DEAD_CYCLES: an=all 1, seg=7'h7F, dp_n=1.
//  - Otherwise the digit at idx is active: an[idx]=0, other an bits=1, seg=decode(code), dp_n=~dp[idx].
//  - Suppressed digit (blank[i]=1 or leading-zero blanked): an stays all 1, seg=7'h7F, dp_n=1 for that slot.
//  - Leading-zero blanking (lzb_en=1): digit i>0 is blanked iff it and every digit above it
//    have code 0 and dp 0. Digit 0 is never LZ-blanked.
//  - Decode: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010,
//    7 1111000, 8 0000000, 9 0010000. HEX_MODE=1: A 0001000, b 0000011, C 1000110, d 0100001,
//    E 0000110, F 0001110. HEX_MODE=0: codes 10-15 display as 9.
//  - frame_tick=1 for exactly the one cycle after a capture cycle; period = NUM_DIGITS*REFRESH_DIV.
//  - rst asserted mid-frame: on the next edge all state returns to its reset values, and the scan
//    restarts at digit 0 with a fresh capture. rst has priority over all other events.
//  - Widths: cnt = $clog2(REFRESH_DIV); idx = max(1,$clog2(NUM_DIGITS)).
// STRUCTURE
//  - Package sevenseg_pkg: SEG_* active-low pattern constants (0-9, A-F) and SEG_OFF = 7'h7F.
//  - Sub-module sevenseg_hex_decode (combinational, parameter HEX_MODE): 4-bit code -> 7-bit pattern.
//  - Top: prescaler, scan index, shadow capture, LZB mask (combinational from the shadow),
//    output registers.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2 unless stated)
//  1. Hold rst for 3 clks -> an=4'b1111, seg=7'h7F, dp_n=1, frame_tick=0 during rst and on the cycle after.
//  2. digits=16'h1234, dp=0, blank=0, lzb_en=0 -> digit-0 slot: 2 clks dark, then 6 clks
//     an=4'b1110, seg=7'b0011001; next slot an=4'b1101, seg=7'b0110000; frame_tick every 32 clks.
//  3. digits=16'h000B: HEX_MODE=0 -> digit 0 seg=7'b0010000; HEX_MODE=1 -> seg=7'b0000011.
//  4. lzb_en=1, digits=16'h0050 -> an stays 4'b1111 in the slots of digits 3 and 2; digit 1 shows '5',
//     digit 0 shows '0'. With digits=16'h0005, dp=4'b0100 -> digit 2 shows '0' with dp_n=0.
//  5. digits changes 16'h1234 -> 16'h5678 during the digit-1 slot -> digits 2,3 of that frame
//     show '2','1'; the next frame shows 8,7,6,5.
//  6. Pulse rst during the digit-2 slot -> next cycle outputs are at reset values;
//     the scan resumes at digit 0 with cnt=0, and frame_tick fires 1 clk after the new capture.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Seven-segment pattern constants (active low, seg[0]=a ... seg[6]=g) and the code-to-pattern helper.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Codes 10..15 show the hex letters when hex is set, otherwise they clamp to '9'.
  function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex);
    logic [6:0] v_seg;
    case (code)
      4'd0:    v_seg = SEG_0;
      4'd1:    v_seg = SEG_1;
      4'd2:    v_seg = SEG_2;
      4'd3:    v_seg = SEG_3;
      4'd4:    v_seg = SEG_4;
      4'd5:    v_seg = SEG_5;
      4'd6:    v_seg = SEG_6;
      4'd7:    v_seg = SEG_7;
      4'd8:    v_seg = SEG_8;
      4'd9:    v_seg = SEG_9;
      4'd10:   v_seg = hex ? SEG_A : SEG_9;
      4'd11:   v_seg = hex ? SEG_B : SEG_9;
      4'd12:   v_seg = hex ? SEG_C : SEG_9;
      4'd13:   v_seg = hex ? SEG_D : SEG_9;
      4'd14:   v_seg = hex ? SEG_E : SEG_9;
      default: v_seg = hex ? SEG_F : SEG_9;
    endcase
    return v_seg;
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Per-digit combinational decoder: 4-bit code -> active-low segment pattern.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = seg_decode(i_code, (HEX_MODE != 0));

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame input capture,
// dead time at the start of every slot, blank mask and leading-zero blanking.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int HEX_MODE    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lzb_en,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp_n,
  output logic                    o_frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                r_cnt;
  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_dig;
  logic [NUM_DIGITS-1:0]        r_dp;
  logic [NUM_DIGITS-1:0]        r_blank;
  logic                         r_lzb;

  logic                         w_cnt_wrap;
  logic                         w_idx_wrap;
  logic                         w_capture;
  logic                         w_dead;
  logic [NUM_DIGITS-1:0]        w_sel;
  logic [NUM_DIGITS-1:0]        w_lz_chain;
  logic [NUM_DIGITS-1:0]        w_supp;
  logic [NUM_DIGITS-1:0][6:0]   w_dec;
  logic [NUM_DIGITS-1:0]        w_an_n;
  logic [6:0]                   w_seg;
  logic                         w_dp_on;
  logic                         w_lit;

  assign w_cnt_wrap = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_idx_wrap = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_capture  = (r_cnt == '0) && (r_idx == '0);
  assign w_dead     = (r_cnt < CW'(DEAD_CYCLES));

  // Prescaler and scan index: one digit slot per REFRESH_DIV clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= w_idx_wrap ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow capture at the start of each frame so a frame never mixes old and new inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dig   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_lzb   <= 1'b0;
    end else if (w_capture) begin
      r_dig   <= i_digits;
      r_dp    <= i_dp;
      r_blank <= i_blank;
      r_lzb   <= i_lzb_en;
    end
  end

  // One decoder per digit; the active slot picks its pattern below.
  sevenseg_hex_decode #(.HEX_MODE(HEX_MODE)) u_dec [NUM_DIGITS-1:0] (
    .i_code (r_dig),
    .o_seg  (w_dec)
  );

  // Leading-zero run from the top digit down: bit i set when digit i and all above are 0 without dp.
  always_comb begin
    logic v_run;
    v_run      = 1'b1;
    w_lz_chain = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run         = v_run & (r_dig[i] == 4'd0) & ~r_dp[i];
      w_lz_chain[i] = v_run;
    end
  end

  // Per-digit slot select and suppression (digit 0 is never LZ-blanked).
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    assign w_sel[gi] = (r_idx == IW'(gi));
    if (gi == 0) begin : g_lsd
      assign w_supp[gi] = r_blank[gi];
    end else begin : g_upper
      assign w_supp[gi] = r_blank[gi] | (r_lzb & w_lz_chain[gi]);
    end
    assign w_an_n[gi] = ~(w_sel[gi] & ~w_supp[gi]);
  end

  // Mux the active digit's pattern and dp request.
  always_comb begin
    w_seg   = SEG_OFF;
    w_dp_on = 1'b0;
    w_lit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) begin
        w_seg   = w_dec[i];
        w_dp_on = r_dp[i];
        w_lit   = ~w_supp[i];
      end
    end
  end

  // Registered pin drivers: dark during dead time or for a suppressed digit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= '1;
      o_seg        <= SEG_OFF;
      o_dp_n       <= 1'b1;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= w_capture;
      if (w_dead || !w_lit) begin
        o_an   <= '1;
        o_seg  <= SEG_OFF;
        o_dp_n <= 1'b1;
      end else begin
        o_an   <= w_an_n;
        o_seg  <= w_seg;
        o_dp_n <= ~w_dp_on;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench: directed scenarios plus randomized inputs, checked every cycle against a
// position-based reference model of the scan (two instances: clamp and hex decode).
module tb_sevenseg_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;

  logic        gclk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic        lzb;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dpn0, dpn1, ft0, ft1;

  always #5 gclk = ~gclk;

  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .HEX_MODE(0)) u_dut0 (
    .i_clk(gclk), .i_rst(rst), .i_digits(digits), .i_dp(dp), .i_blank(blank), .i_lzb_en(lzb),
    .o_an(an0), .o_seg(seg0), .o_dp_n(dpn0), .o_frame_tick(ft0));

  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .HEX_MODE(1)) u_dut1 (
    .i_clk(gclk), .i_rst(rst), .i_digits(digits), .i_dp(dp), .i_blank(blank), .i_lzb_en(lzb),
    .o_an(an1), .o_seg(seg1), .o_dp_n(dpn1), .o_frame_tick(ft1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state: frame position since reset release and the captured frame.
  int          p = 0;
  logic [15:0] m_dig  = '0;
  logic [3:0]  m_dp   = '0, m_blank = '0;
  logic        m_lzb  = 1'b0;
  int          sh_idx = -1, sh_cnt = -1;
  int          cyc = 0, last_ft = -1;

  function automatic logic [6:0] ref_seg(input int code, input bit hex);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    if (!hex && code >= 10) return tbl[9];
    return tbl[code];
  endfunction

  // One clock with full model comparison of both instances.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_s0, e_s1;
    logic       e_dpn, e_ft;
    int         c, k, code;
    bit         supp, zero_run;
    e_an = 4'hF; e_s0 = 7'h7F; e_s1 = 7'h7F; e_dpn = 1'b1; e_ft = 1'b0;
    if (rst) begin
      p = 0; m_dig = '0; m_dp = '0; m_blank = '0; m_lzb = 1'b0;
      sh_idx = -1; sh_cnt = -1;
    end else begin
      c = p % R;
      k = (p / R) % N;
      e_ft = ((p % (N * R)) == 0);
      zero_run = 1'b1;
      for (int j = k; j < N; j++)
        if (m_dig[4*j +: 4] != 4'd0 || m_dp[j]) zero_run = 1'b0;
      supp = m_blank[k] || (m_lzb && k > 0 && zero_run);
      if (c >= D && !supp) begin
        code  = int'(m_dig[4*k +: 4]);
        e_an  = ~(4'b0001 << k);
        e_s0  = ref_seg(code, 1'b0);
        e_s1  = ref_seg(code, 1'b1);
        e_dpn = ~m_dp[k];
      end
      if (e_ft) begin
        m_dig = digits; m_dp = dp; m_blank = blank; m_lzb = lzb;
      end
      sh_idx = k; sh_cnt = c;
      p++;
    end
    @(posedge gclk);
    #1;
    cyc++;
    chk("an0", 32'(an0), 32'(e_an));
    chk("an1", 32'(an1), 32'(e_an));
    chk("seg0", 32'(seg0), 32'(e_s0));
    chk("seg1", 32'(seg1), 32'(e_s1));
    chk("dpn0", 32'(dpn0), 32'(e_dpn));
    chk("dpn1", 32'(dpn1), 32'(e_dpn));
    chk("ft0", 32'(ft0), 32'(e_ft));
    chk("ft1", 32'(ft1), 32'(e_ft));
    if (rst) last_ft = -1;
    else if (ft0) begin
      if (last_ft >= 0) chk("ft_period", 32'(cyc - last_ft), 32'(N * R));
      last_ft = cyc;
    end
  endtask

  // Advance until the output shows slot (idx, cnt); bounded.
  task automatic run_until(input int ti, input int tc);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 3 * N * R && !found; n++) begin
      tick();
      if (sh_idx == ti && sh_cnt == tc) found = 1'b1;
    end
    chk("run_until", 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b1; digits = 16'h1234; dp = '0; blank = '0; lzb = 1'b0;
    // 1: reset held 3 clocks
    repeat (3) tick();
    chk("t1_an", 32'(an0), 32'hF);
    chk("t1_seg", 32'(seg0), 32'h7F);
    chk("t1_ft", 32'(ft0), 32'd0);
    rst = 1'b0;
    tick();
    chk("t1_cap_ft", 32'(ft0), 32'd1);
    chk("t1_cap_dark", 32'(an0), 32'hF);
    // 2: basic scan of 1234
    run_until(0, 1);
    chk("t2_dead", 32'(an0), 32'hF);
    run_until(0, 2);
    chk("t2_an0", 32'(an0), 32'(4'b1110));
    chk("t2_seg0", 32'(seg0), 32'(7'b0011001));
    run_until(0, 7);
    chk("t2_an0_end", 32'(an0), 32'(4'b1110));
    run_until(1, 2);
    chk("t2_an1", 32'(an0), 32'(4'b1101));
    chk("t2_seg1", 32'(seg0), 32'(7'b0110000));
    // 3: code B, clamp vs hex
    digits = 16'h000B;
    run_until(0, 0);
    run_until(0, 2);
    chk("t3_clamp", 32'(seg0), 32'(7'b0010000));
    chk("t3_hex", 32'(seg1), 32'(7'b0000011));
    // 4: leading-zero blanking
    lzb = 1'b1; digits = 16'h0050;
    run_until(0, 0);
    run_until(0, 2);
    chk("t4_d0_an", 32'(an0), 32'(4'b1110));
    chk("t4_d0_seg", 32'(seg0), 32'(7'b1000000));
    run_until(1, 2);
    chk("t4_d1_seg", 32'(seg0), 32'(7'b0010010));
    run_until(2, 2);
    chk("t4_d2_an", 32'(an0), 32'hF);
    run_until(3, 2);
    chk("t4_d3_an", 32'(an0), 32'hF);
    digits = 16'h0005; dp = 4'b0100;
    run_until(0, 0);
    run_until(2, 2);
    chk("t4_dp_an", 32'(an0), 32'(4'b1011));
    chk("t4_dp_seg", 32'(seg0), 32'(7'b1000000));
    chk("t4_dp_n", 32'(dpn0), 32'd0);
    run_until(3, 2);
    chk("t4_dp_d3", 32'(an0), 32'hF);
    // 5: mid-frame change is deferred to the next frame
    lzb = 1'b0; dp = '0; digits = 16'h1234;
    run_until(0, 0);
    run_until(1, 3);
    digits = 16'h5678;
    run_until(2, 2); chk("t5_d2", 32'(seg0), 32'(7'b0100100));
    run_until(3, 2); chk("t5_d3", 32'(seg0), 32'(7'b1111001));
    run_until(0, 2); chk("t5_n0", 32'(seg0), 32'(7'b0000000));
    run_until(1, 2); chk("t5_n1", 32'(seg0), 32'(7'b1111000));
    run_until(2, 2); chk("t5_n2", 32'(seg0), 32'(7'b0000010));
    run_until(3, 2); chk("t5_n3", 32'(seg0), 32'(7'b0010010));
    // 6: reset pulse mid-frame
    run_until(2, 4);
    rst = 1'b1;
    tick();
    chk("t6_an", 32'(an0), 32'hF);
    chk("t6_ft", 32'(ft0), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_ft_cap", 32'(ft0), 32'd1);
    run_until(0, 2);
    chk("t6_resume", 32'(an0), 32'(4'b1110));
    // Randomized inputs, biased toward zero digits, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < N; j++)
          digits[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        lzb   = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
